// File: rtl/approx_seq_divider.sv
// Restoring divider (16/8) producing one quotient bit per clock.
// mask=0 skips the low TRUNC quotient bits for a shorter, approximate result.
module approx_seq_divider #(
  parameter int TRUNC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in1,
  input  logic [7:0]  in2,
  input  logic        mask,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic        div_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring iteration per cycle, cnt counts down to 1
  // DZ    | single busy cycle for a zero divisor
  // FIN   | done pulse, results valid; a new start is accepted here
  typedef enum logic [1:0] {IDLE, RUN, DZ, FIN} state_t;

  localparam logic [4:0] K_EXACT  = 5'd16;
  localparam logic [4:0] K_APPROX = 5'(16 - TRUNC);

  state_t      state, state_nx;
  logic        accept, last_iter, q_bit;
  logic [15:0] dvd, q_wk, q_nx;
  logic [7:0]  dvs, p, p_nx;
  logic [8:0]  p_sh;
  logic        mask_r;
  logic [4:0]  cnt;

  assign accept    = start && (state == IDLE || state == FIN);
  assign last_iter = (cnt == 5'd1);

  always_comb begin
    p_sh  = {p, dvd[15]};
    q_bit = (p_sh >= {1'b0, dvs});
    p_nx  = q_bit ? 8'(p_sh - {1'b0, dvs}) : p_sh[7:0];
    q_nx  = {q_wk[14:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: begin
        if (accept) state_nx = (in2 == 8'd0) ? DZ : RUN;
        else        state_nx = IDLE;
      end
      RUN:     if (last_iter) state_nx = FIN;
      DZ:      state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DZ: busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd      <= '0;
      dvs      <= '0;
      mask_r   <= 1'b0;
      p        <= '0;
      q_wk     <= '0;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      dvd    <= in1;
      dvs    <= in2;
      mask_r <= mask;
      p      <= '0;
      q_wk   <= '0;
      cnt    <= mask ? K_EXACT : K_APPROX;
    end else if (state == RUN) begin
      dvd  <= {dvd[14:0], 1'b0};
      p    <= p_nx;
      q_wk <= q_nx;
      cnt  <= cnt - 5'd1;
      // In approximate mode only 16-TRUNC bits were produced; align them to the top.
      if (last_iter) begin
        quot     <= mask_r ? q_nx : (q_nx << TRUNC);
        rem      <= p_nx;
        div_zero <= 1'b0;
      end
    end else if (state == DZ) begin
      quot     <= 16'hFFFF;
      rem      <= dvd[7:0];
      div_zero <= 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_seq_divider.sv
// Directed bench for approx_seq_divider (TRUNC=4): latency, results,
// divide-by-zero, ignored start, abort by reset and back-to-back operation.
module tb_approx_seq_divider;

  logic        clk = 1'b0;
  logic        rst, start, mask;
  logic [15:0] in1;
  logic [7:0]  in2;
  logic        busy, done, div_zero;
  logic [15:0] quot;
  logic [7:0]  rem;

  int tests = 0;
  int fails = 0;
  int lat;
  int seen_done;

  approx_seq_divider #(.TRUNC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .mask(mask),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle, returns the cycle in which done appears (40 = timeout).
  task automatic go(input logic [15:0] a, input logic [7:0] b, input logic m, output int l);
    start = 1'b1; in1 = a; in2 = b; mask = m;
    step();
    start = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mask = 1'b1; in1 = '0; in2 = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dz", div_zero, 0);
    rst = 1'b0;
    step();

    // 1: exact 1980/44
    start = 1'b1; in1 = 16'd1980; in2 = 8'd44; mask = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_c1", busy, 1);
    lat = 1;
    while (!done && lat < 40) begin step(); lat++; end
    check("t1_lat", lat, 17);
    check("t1_busy_done", busy, 0);
    check("t1_quot", quot, 45);
    check("t1_rem", rem, 0);
    check("t1_dz", div_zero, 0);
    step();
    check("t1_done_pulse", done, 0);

    // 2: approximate 1980/44 -> (123/44)<<4
    go(16'd1980, 8'd44, 1'b0, lat);
    check("t2_lat", lat, 13);
    check("t2_quot", quot, 32);
    check("t2_rem", rem, 35);
    step();

    // approximate 65535/255 -> 4095/255 = 16 r 15
    go(16'd65535, 8'd255, 1'b0, lat);
    check("t2b_quot", quot, 256);
    check("t2b_rem", rem, 15);
    step();

    // 3: divide by zero, then exact 100/7
    go(16'h1234, 8'd0, 1'b1, lat);
    check("t3_lat", lat, 2);
    check("t3_quot", quot, 16'hFFFF);
    check("t3_rem", rem, 8'h34);
    check("t3_dz", div_zero, 1);
    step();
    go(16'd100, 8'd7, 1'b1, lat);
    check("t3b_quot", quot, 14);
    check("t3b_rem", rem, 2);
    check("t3b_dz", div_zero, 0);
    step();

    // 4: start in cycle 5 is ignored while busy
    start = 1'b1; in1 = 16'd65535; in2 = 8'd255; mask = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (lat < 5) begin step(); lat++; end
    check("t4_hold_quot", quot, 14);
    start = 1'b1; in1 = 16'd10; in2 = 8'd3; mask = 1'b0;
    step(); lat++;
    start = 1'b0;
    while (!done && lat < 40) begin step(); lat++; end
    check("t4_lat", lat, 17);
    check("t4_quot", quot, 257);
    check("t4_rem", rem, 0);
    step();

    // 5: reset in cycle 8 aborts the operation
    start = 1'b1; in1 = 16'd1980; in2 = 8'd44; mask = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (lat < 8) begin step(); lat++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_quot", quot, 0);
    check("t5_rem", rem, 0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen_done++;
      step();
    end
    check("t5_no_done", seen_done, 0);
    go(16'd1980, 8'd44, 1'b1, lat);
    check("t5b_lat", lat, 17);
    check("t5b_quot", quot, 45);
    check("t5b_rem", rem, 0);

    // 6: start in the done cycle is accepted
    go(16'd200, 8'd9, 1'b1, lat);
    check("t6_lat", lat, 17);
    check("t6_quot", quot, 22);
    check("t6_rem", rem, 2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/approx_seq_divider.md
Name: approx_seq_divider

Overview:
- Sequential restoring divider with accuracy control: 16-bit dividend, 8-bit divisor.
- Inverse-direction companion to the approximate 8x8 accuracy-controllable multiplier: it recovers an operand from a 16-bit product.
- mask selects exact division or truncated, lower-latency approximate division.
- Start/busy/done handshake; one quotient bit per clock.

Parameters:
- TRUNC, 4, number of low quotient bits skipped in approximate mode (legal range 0..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- in1  input  16  dividend; captured on an accepted start.
- in2  input  8  divisor; captured on an accepted start.
- mask  input  1  1 = exact (16 iterations), 0 = approximate (16-TRUNC iterations); captured on an accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; quot/rem/div_zero are valid from this cycle on.
- quot  output  16  quotient.
- rem  output  8  remainder.
- div_zero  output  1  last completed operation had in2 = 0.

Behaviour:
- Reset: busy=0, done=0, quot=0, rem=0, div_zero=0, iteration counter=0.
- Reset wins over every other input. Asserted mid-operation it aborts the operation: no done is issued and the outputs are cleared.

State machine:
- IDLE -> RUN when start=1 and in2!=0.
- IDLE -> DZ when start=1 and in2=0.
- RUN -> FIN after the last iteration.
- DZ -> FIN.
- FIN -> IDLE.

Handshake and latency:
- start is accepted in cycle N (busy=0). busy=1 from cycle N+1.
- RUN performs one iteration per cycle over cycles N+1..N+K.
  - K = 16 when mask=1.
  - K = 16-TRUNC when mask=0.
- done=1 and busy=0 in cycle N+K+1.
- Exact-mode latency is 17 cycles; approximate-mode latency is 17-TRUNC cycles.
- start while busy=1 is ignored; operands and mask are not re-sampled.
- start in a done cycle is accepted (busy=0 there).

Iteration:
- 9-bit partial remainder P, initialised to 0.
- Each step: P = {P[7:0], next dividend bit (MSB first)}.
- If P >= in2: P = P - in2 and the quotient bit is 1; otherwise the quotient bit is 0.

Results:
- Exact: quot = floor(in1/in2), rem = in1 mod in2.
- Approximate:
  - quot = floor((in1>>TRUNC)/in2) << TRUNC, i.e. the low TRUNC bits are 0 and the upper bits are exact.
  - rem = (in1>>TRUNC) mod in2.
- rem always fits in 8 bits because P < in2 after each step.

Divide-by-zero:
- One busy cycle (DZ), then done in cycle N+2.
- quot = 16'hFFFF, rem = in1[7:0], div_zero = 1.
- Any non-zero divide clears div_zero at its done.

Output hold:
- quot, rem and div_zero hold their values until the next done or reset.
- They do not change while busy.

Test Plan:
1. in1=1980, in2=44, mask=1, start in cycle 0 -> done in cycle 17, quot=45, rem=0, div_zero=0.
2. TRUNC=4, in1=1980, in2=44, mask=0 -> done in cycle 13, quot=32, rem=35.
3. in1=16'h1234, in2=0, start -> done in cycle 2, quot=16'hFFFF, rem=8'h34, div_zero=1; a following 100/7 exact divide -> quot=14, rem=2, div_zero=0.
4. in1=65535, in2=255, mask=1 start; in cycle 5 start with in1=10, in2=3 -> second start ignored, done in cycle 17 with quot=257, rem=0.
5. Exact start, rst=1 in cycle 8 -> busy=0, quot=0, rem=0 from cycle 9; no done ever appears; a new 1980/44 start afterwards completes normally.
6. Back-to-back: second start (in1=200, in2=9) asserted in the first op's done cycle -> accepted; done 17 cycles later with quot=22, rem=2.
